// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line/frame counters with registered active-area flags and wrap pulses.
// The flags are decoded from the next-state counters so they always match the registered counts.
module vga_timing_gen #(
    parameter int XWIDTH = 10,
    parameter int YWIDTH = 10,
    parameter int HACT   = 640,
    parameter int HTOTAL = 800,
    parameter int VACT   = 480,
    parameter int VTOTAL = 525
) (
    input  logic              PixelClk,
    input  logic              RstN,
    input  logic              Enable,
    output logic [XWIDTH-1:0] PixelCnt,
    output logic [YWIDTH-1:0] LineCnt,
    output logic              IsActHorz,
    output logic              IsActVert,
    output logic              LineStart,
    output logic              FrameStart,
    output logic [7:0]        FrameCnt
);
    if (HACT <= 0 || HACT >= HTOTAL || longint'(HTOTAL) > (longint'(1) << XWIDTH)) begin : g_bad_h
        $error("vga_timing_gen: illegal horizontal parameters");
    end
    if (VACT <= 0 || VACT >= VTOTAL || longint'(VTOTAL) > (longint'(1) << YWIDTH)) begin : g_bad_v
        $error("vga_timing_gen: illegal vertical parameters");
    end

    localparam logic [XWIDTH-1:0] H_LAST = XWIDTH'(HTOTAL - 1);
    localparam logic [XWIDTH-1:0] H_ACT  = XWIDTH'(HACT);
    localparam logic [YWIDTH-1:0] V_LAST = YWIDTH'(VTOTAL - 1);
    localparam logic [YWIDTH-1:0] V_ACT  = YWIDTH'(VACT);

    logic [XWIDTH-1:0] pix_q, pix_d;
    logic [YWIDTH-1:0] line_q, line_d;
    logic [7:0]        frame_q, frame_d;
    logic              act_h_q, act_h_d, act_v_q, act_v_d;
    logic              line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic              wrap_h, wrap_v;

    always_comb begin
        wrap_h        = Enable && (pix_q == H_LAST);
        wrap_v        = wrap_h && (line_q == V_LAST);
        pix_d         = Enable ? (wrap_h ? '0 : pix_q + XWIDTH'(1)) : pix_q;
        line_d        = wrap_h ? (wrap_v ? '0 : line_q + YWIDTH'(1)) : line_q;
        frame_d       = wrap_v ? frame_q + 8'd1 : frame_q;
        act_h_d       = pix_d < H_ACT;
        act_v_d       = line_d < V_ACT;
        line_start_d  = wrap_h;
        frame_start_d = wrap_v;
    end

    always_ff @(posedge PixelClk or negedge RstN) begin
        if (!RstN) begin
            pix_q         <= '0;
            line_q        <= '0;
            frame_q       <= '0;
            act_h_q       <= 1'b1;
            act_v_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_q         <= pix_d;
            line_q        <= line_d;
            frame_q       <= frame_d;
            act_h_q       <= act_h_d;
            act_v_q       <= act_v_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PixelCnt   = pix_q;
    assign LineCnt    = line_q;
    assign FrameCnt   = frame_q;
    assign IsActHorz  = act_h_q;
    assign IsActVert  = act_v_q;
    assign LineStart  = line_start_q;
    assign FrameStart = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three timing generators checked every cycle against an enabled-edge tick model.
// Unit 0 uses default timing, unit 1 a tiny 4x3 raster, unit 2 a narrow 8-pixel line with full height.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n, en;
    logic [9:0] pc[3], lc[3];
    logic [7:0] fc[3];
    logic       ah[3], av[3], ls[3], fs[3];
    int         checks = 0, failures = 0;
    bit         live = 1'b0;

    vga_timing_gen u0 (.PixelClk(clk), .RstN(rst_n[0]), .Enable(en[0]), .PixelCnt(pc[0]), .LineCnt(lc[0]),
        .IsActHorz(ah[0]), .IsActVert(av[0]), .LineStart(ls[0]), .FrameStart(fs[0]), .FrameCnt(fc[0]));
    vga_timing_gen #(.HACT(2), .HTOTAL(4), .VACT(2), .VTOTAL(3)) u1 (.PixelClk(clk), .RstN(rst_n[1]),
        .Enable(en[1]), .PixelCnt(pc[1]), .LineCnt(lc[1]), .IsActHorz(ah[1]), .IsActVert(av[1]),
        .LineStart(ls[1]), .FrameStart(fs[1]), .FrameCnt(fc[1]));
    vga_timing_gen #(.HACT(5), .HTOTAL(8)) u2 (.PixelClk(clk), .RstN(rst_n[2]), .Enable(en[2]),
        .PixelCnt(pc[2]), .LineCnt(lc[2]), .IsActHorz(ah[2]), .IsActVert(av[2]), .LineStart(ls[2]),
        .FrameStart(fs[2]), .FrameCnt(fc[2]));

    function automatic int ht(input int i); return i == 0 ? 800 : i == 1 ? 4 : 8; endfunction
    function automatic int ha(input int i); return i == 0 ? 640 : i == 1 ? 2 : 5; endfunction
    function automatic int vt(input int i); return i == 1 ? 3 : 525; endfunction
    function automatic int va(input int i); return i == 1 ? 2 : 480; endfunction

    // The model only counts enabled edges since reset; position follows from division.
    for (genvar g = 0; g < 3; g++) begin : g_m
        int unsigned ticks;
        bit          ls_e, fs_e;
        always @(posedge clk or negedge rst_n[g]) begin
            if (!rst_n[g]) begin
                ticks <= 0;
                ls_e  <= 1'b0;
                fs_e  <= 1'b0;
            end else begin
                ls_e <= en[g] && ((ticks + 1) % ht(g) == 0);
                fs_e <= en[g] && ((ticks + 1) % (ht(g) * vt(g)) == 0);
                if (en[g]) ticks <= ticks + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp(input int i, input int unsigned t, input bit lse, input bit fse);
        int unsigned p, l;
        p = t % ht(i);
        l = (t / ht(i)) % vt(i);
        chk($sformatf("u%0d.pix", i), 32'(pc[i]), p);
        chk($sformatf("u%0d.line", i), 32'(lc[i]), l);
        chk($sformatf("u%0d.frame", i), 32'(fc[i]), (t / (ht(i) * vt(i))) % 256);
        chk($sformatf("u%0d.acth", i), 32'(ah[i]), 32'(p < ha(i)));
        chk($sformatf("u%0d.actv", i), 32'(av[i]), 32'(l < va(i)));
        chk($sformatf("u%0d.ls", i), 32'(ls[i]), 32'(lse));
        chk($sformatf("u%0d.fs", i), 32'(fs[i]), 32'(fse));
    endtask

    always @(negedge clk) begin
        if (live) begin
            cmp(0, g_m[0].ticks, g_m[0].ls_e, g_m[0].fs_e);
            cmp(1, g_m[1].ticks, g_m[1].ls_e, g_m[1].fs_e);
            cmp(2, g_m[2].ticks, g_m[2].ls_e, g_m[2].fs_e);
        end
    end

    task automatic chk_reset(input int i, input string tag);
        chk({tag, ".pix"}, 32'(pc[i]), 0);
        chk({tag, ".line"}, 32'(lc[i]), 0);
        chk({tag, ".frame"}, 32'(fc[i]), 0);
        chk({tag, ".acth"}, 32'(ah[i]), 1);
        chk({tag, ".actv"}, 32'(av[i]), 1);
        chk({tag, ".ls"}, 32'(ls[i]), 0);
        chk({tag, ".fs"}, 32'(fs[i]), 0);
    endtask

    initial begin
        int n;
        rst_n = 3'b111;
        en    = 3'b000;
        #1 rst_n = 3'b000;
        #2 live = 1'b1;
        chk_reset(0, "rst0");
        // default timing: first line wrap and horizontal boundary
        @(negedge clk); rst_n[0] = 1'b1; en[0] = 1'b1;
        repeat (799) @(negedge clk);
        chk("l.pix799", 32'(pc[0]), 799); chk("l.acth799", 32'(ah[0]), 0); chk("l.ls799", 32'(ls[0]), 0);
        @(negedge clk);
        chk("l.wrap.pix", 32'(pc[0]), 0); chk("l.wrap.line", 32'(lc[0]), 1);
        chk("l.wrap.ls", 32'(ls[0]), 1); chk("l.wrap.acth", 32'(ah[0]), 1);
        @(negedge clk);
        chk("l.ls.clear", 32'(ls[0]), 0); chk("l.pix1", 32'(pc[0]), 1);
        repeat (638) @(negedge clk);
        chk("l.pix639", 32'(pc[0]), 639); chk("l.acth639", 32'(ah[0]), 1);
        @(negedge clk);
        chk("l.pix640", 32'(pc[0]), 640); chk("l.acth640", 32'(ah[0]), 0);
        // pause right after a wrap with the pulse pending
        repeat (159) @(negedge clk);
        @(negedge clk);
        chk("p.ls", 32'(ls[0]), 1); chk("p.line", 32'(lc[0]), 2);
        en[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("p.hold.pix", 32'(pc[0]), 0); chk("p.hold.line", 32'(lc[0]), 2); chk("p.hold.ls", 32'(ls[0]), 0);
        en[0] = 1'b1;
        @(negedge clk);
        chk("p.resume", 32'(pc[0]), 1);
        // pause at the last pixel; the wrap happens only once enabled again
        repeat (798) @(negedge clk);
        en[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("q.hold.pix", 32'(pc[0]), 799); chk("q.hold.ls", 32'(ls[0]), 0);
        en[0] = 1'b1;
        @(negedge clk);
        chk("q.pix", 32'(pc[0]), 0); chk("q.line", 32'(lc[0]), 3); chk("q.ls", 32'(ls[0]), 1);
        // asynchronous reset mid-line
        repeat (123) @(negedge clk);
        chk("r.pix123", 32'(pc[0]), 123);
        #2 rst_n[0] = 1'b0;
        #1 chk_reset(0, "r0.async");
        @(negedge clk); @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("r.pix1", 32'(pc[0]), 1); chk("r.ls", 32'(ls[0]), 0); chk("r.fs", 32'(fs[0]), 0);
        // tiny raster: frame every 12 cycles, FrameCnt wraps
        rst_n[1] = 1'b1; en[1] = 1'b1;
        n = 0;
        repeat (3060) begin
            @(negedge clk);
            if (fs[1]) n++;
        end
        chk("s.fs.count", 32'(n), 255); chk("s.frame255", 32'(fc[1]), 255); chk("s.fs", 32'(fs[1]), 1);
        repeat (12) @(negedge clk);
        chk("s.frame.wrap", 32'(fc[1]), 0); chk("s.fs.wrap", 32'(fs[1]), 1);
        @(negedge clk);
        chk("s.fs.clear", 32'(fs[1]), 0);
        // narrow line, full height: vertical boundary and frame wrap
        rst_n[2] = 1'b1; en[2] = 1'b1;
        repeat (3832) @(negedge clk);
        chk("v.line479", 32'(lc[2]), 479); chk("v.actv479", 32'(av[2]), 1);
        repeat (8) @(negedge clk);
        chk("v.line480", 32'(lc[2]), 480); chk("v.actv480", 32'(av[2]), 0);
        repeat (359) @(negedge clk);
        chk("f.pix7", 32'(pc[2]), 7); chk("f.line524", 32'(lc[2]), 524); chk("f.frame0", 32'(fc[2]), 0);
        @(negedge clk);
        chk("f.pix", 32'(pc[2]), 0); chk("f.line", 32'(lc[2]), 0); chk("f.fs", 32'(fs[2]), 1);
        chk("f.ls", 32'(ls[2]), 1); chk("f.frame", 32'(fc[2]), 1); chk("f.actv", 32'(av[2]), 1);
        repeat (2403) @(negedge clk);
        chk("m.line300", 32'(lc[2]), 300); chk("m.pix3", 32'(pc[2]), 3);
        #2 rst_n[2] = 1'b0;
        #1 chk_reset(2, "r2.async");
        @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("m.no.fs", 32'(fs[2]), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
